frame_streamer: RTL

FRAME_STREAMER -- requirements
Module: frame_streamer

---
 rtl/doodle_pkg.sv | 15 +
 rtl/frame_streamer_if.sv | 26 ++
 rtl/frame_streamer_xy_counter.sv | 36 +++
 rtl/frame_streamer.sv | 108 ++++++++++
 4 files changed

// File: rtl/doodle_pkg.sv
// rtl/doodle_pkg.sv - screen geometry and streamer FSM states shared with GameBox
package doodle_pkg;

  localparam int SCR_W = 30;
  localparam int SCR_H = 30;
  localparam int PIX_W = 24;
  localparam int XY_W  = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } fs_state_t;

endpackage

// File: rtl/frame_streamer_if.sv
// rtl/frame_streamer_if.sv - pixel stream handshake between the streamer and its sink
interface frame_streamer_if #(
  parameter int PIX_W = doodle_pkg::PIX_W,
  parameter int XY_W  = doodle_pkg::XY_W
);

  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] pix_data;
  logic [XY_W-1:0]  pix_x;
  logic [XY_W-1:0]  pix_y;
  logic             sof;
  logic             eol;
  logic             eof;

  modport master (
    output pix_valid, pix_data, pix_x, pix_y, sof, eol, eof,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_data, pix_x, pix_y, sof, eol, eof,
    output pix_ready
  );

endinterface

// File: rtl/frame_streamer_xy_counter.sv
// rtl/frame_streamer_xy_counter.sv - row-major x/y position counter with end-of-frame flag
module xy_counter #(
  parameter int SCR_W = doodle_pkg::SCR_W,
  parameter int SCR_H = doodle_pkg::SCR_H,
  parameter int XY_W  = doodle_pkg::XY_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            advance,
  output logic [XY_W-1:0] x,
  output logic [XY_W-1:0] y,
  output logic            last
);

  logic x_end;

  assign x_end = (x == XY_W'(SCR_W - 1));
  assign last  = x_end && (y == XY_W'(SCR_H - 1));

  // Wrapping back to (0,0) after the last pixel leaves the counter ready for the next frame.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x_end) begin
        x <= '0;
        y <= last ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_streamer.sv
// rtl/frame_streamer.sv - snapshots a GameBox frame and streams it pixel by pixel
module frame_streamer #(
  parameter int SCR_W = doodle_pkg::SCR_W,
  parameter int SCR_H = doodle_pkg::SCR_H,
  parameter int PIX_W = doodle_pkg::PIX_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [PIX_W*SCR_W*SCR_H-1:0] screen,
  input  logic                         frame_start,
  frame_streamer_if.master             pix,
  output logic                         busy,
  output logic                         frame_done,
  output logic [7:0]                   drop_cnt
);

  import doodle_pkg::*;

  localparam int NPIX  = SCR_W * SCR_H;
  localparam int IDX_W = $clog2(NPIX);

  fs_state_t        state;
  logic [PIX_W-1:0] snap [NPIX];
  logic [XY_W-1:0]  x;
  logic [XY_W-1:0]  y;
  logic             last;
  logic             start_ok;
  logic             xfer;
  logic [IDX_W-1:0] idx;

  assign start_ok = reset && (state == IDLE) && frame_start;
  assign xfer     = pix.pix_valid && pix.pix_ready;

  xy_counter #(
    .SCR_W (SCR_W),
    .SCR_H (SCR_H),
    .XY_W  (XY_W)
  ) u_xy (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_ok),
    .advance (xfer),
    .x       (x),
    .y       (y),
    .last    (last)
  );

  // The snapshot needs no reset: it is only observable while pix_valid is high.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      for (int i = 0; i < NPIX; i++) begin
        snap[i] <= screen[PIX_W*i +: PIX_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      pix.pix_valid <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      if (frame_start && (state != IDLE) && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (frame_start) begin
            state         <= STREAM;
            pix.pix_valid <= 1'b1;
            busy          <= 1'b1;
          end
        end
        STREAM: begin
          if (xfer && last) begin
            state         <= DONE;
            pix.pix_valid <= 1'b0;
            frame_done    <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          frame_done <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          pix.pix_valid <= 1'b0;
          busy          <= 1'b0;
          frame_done    <= 1'b0;
        end
      endcase
    end
  end

  // Everything below is decoded from registers only, so it holds still during a stall.
  assign idx = IDX_W'(y) * IDX_W'(SCR_W) + IDX_W'(x);

  assign pix.pix_x    = x;
  assign pix.pix_y    = y;
  assign pix.pix_data = pix.pix_valid ? snap[idx] : '0;
  assign pix.sof      = pix.pix_valid && (x == '0) && (y == '0);
  assign pix.eol      = pix.pix_valid && (x == XY_W'(SCR_W - 1));
  assign pix.eof      = pix.pix_valid && last;

endmodule
